// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Fetch front end and producer side of the instruction-buffer interface. It
// keeps the fetch PC and issues one 16-byte-aligned request to instruction
// memory at a time. Each 128-bit response line becomes a 4-wide instruction
// group. A slot valid mask drops the words that sit before the fetch PC inside
// the line. The group is then offered downstream with a valid/ready handshake.
// A redirect (branch or exception) loads a new PC and kills any fetch still in
// flight.
//
// Parameters
//   ADDR_W            PC / request address width
//   RESET_PC          PC loaded on reset
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   memory request handshake
//   req_addr          line address of the current PC, low 4 bits zero
//   resp_valid/data   memory response (always accepted); word i = [32i+31:32i]
//   redirect_valid/pc front-end redirect; redirect_pc is word aligned
//   inst_group        4 instructions of the fetched line
//   inst_group_valid  bit i set when slot i holds a valid instruction
//   group_pc          PC of the first valid slot
//   out_valid         group valid towards the instruction buffer
//   next_ready        instruction buffer can accept
//
// Optional build macro IFU_PERF_CNT_EN adds three 32-bit wrapping counters:
//   perf_stall_cyc    cycles spent holding a group with next_ready low
//   perf_fetch_cnt    groups handed downstream
//   perf_flush_cnt    cycles with redirect_valid asserted
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = 32'h1c00_0000
) (
   input  logic              clk,
   input  logic              rst,
   // instruction memory request
   output logic              req_valid,
   input  logic              req_ready,
   output logic [ADDR_W-1:0] req_addr,
   // instruction memory response
   input  logic              resp_valid,
   input  logic [127:0]      resp_data,
   // redirect
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   // instruction buffer
   output logic [127:0]      inst_group,
   output logic [3:0]        inst_group_valid,
   output logic [ADDR_W-1:0] group_pc,
   output logic              out_valid,
   input  logic              next_ready
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]       perf_stall_cyc,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_OUT,
      S_DROP
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [127:0]        group_q, group_d;
   logic [3:0]          mask_q, mask_d;
   logic [ADDR_W-1:0]   gpc_q, gpc_d;
   logic [ADDR_W-5:0]   line_inc;

   // The slots before the fetch PC inside the line are not part of the
   // instruction stream.
   function automatic logic [3:0] first_mask(input logic [1:0] slot);
      logic [3:0] m;
      case (slot)
         2'd0:    m = 4'b1111;
         2'd1:    m = 4'b1110;
         2'd2:    m = 4'b1100;
         default: m = 4'b1000;
      endcase
      return m;
   endfunction

   // The line index wraps modulo 2^(ADDR_W-4). The PC therefore wraps to zero
   // after the top line.
   assign line_inc = pc_q[ADDR_W-1:4] + {{(ADDR_W-5){1'b0}}, 1'b1};

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      group_d = group_q;
      mask_d  = mask_q;
      gpc_d   = gpc_q;

      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (resp_valid) begin
               state_d = S_OUT;
               group_d = resp_data;
               mask_d  = first_mask(pc_q[3:2]);
               gpc_d   = pc_q;
               pc_d    = {line_inc, 4'b0000};
            end
         end
         S_OUT: begin
            if (next_ready) begin
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (resp_valid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A redirect overrides everything above. A request that was accepted is
      // still owed a response, and S_DROP swallows that response. A group held
      // in S_OUT is handed over if next_ready is high and dropped otherwise.
      // Either way the unit refetches.
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         group_d = group_q;
         mask_d  = mask_q;
         gpc_d   = gpc_q;
         case (state_q)
            S_REQ:   state_d = req_ready  ? S_DROP : S_REQ;
            S_WAIT:  state_d = resp_valid ? S_REQ  : S_DROP;
            S_DROP:  state_d = resp_valid ? S_REQ  : S_DROP;
            default: state_d = S_REQ;
         endcase
      end
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] fetch_cnt_q;
   logic [31:0] flush_cnt_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         group_q <= '0;
         mask_q  <= '0;
         gpc_q   <= '0;
`ifdef IFU_PERF_CNT_EN
         stall_cnt_q <= '0;
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         group_q <= group_d;
         mask_q  <= mask_d;
         gpc_q   <= gpc_d;
`ifdef IFU_PERF_CNT_EN
         if (state_q == S_OUT && !next_ready) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (state_q == S_OUT && next_ready) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (redirect_valid) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
`endif
      end
   end

   // Handshake valids decode only the state register, so no input reaches
   // them combinationally.
   assign req_valid        = (state_q == S_REQ);
   assign out_valid        = (state_q == S_OUT);
   assign req_addr         = {pc_q[ADDR_W-1:4], 4'b0000};
   assign inst_group       = group_q;
   assign inst_group_valid = mask_q;
   assign group_pc         = gpc_q;

`ifdef IFU_PERF_CNT_EN
   assign perf_stall_cyc = stall_cnt_q;
   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h1c00_0000;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_addr;
   logic          resp_valid;
   logic [127:0]  resp_data;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic [127:0]  inst_group;
   logic [3:0]    inst_group_valid;
   logic [31:0]   group_pc;
   logic          out_valid;
   logic          next_ready;
`ifdef IFU_PERF_CNT_EN
   logic [31:0]   perf_stall_cyc;
   logic [31:0]   perf_fetch_cnt;
   logic [31:0]   perf_flush_cnt;
`endif

   inst_fetch_unit #(
      .ADDR_W   (32),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_addr         (req_addr),
      .resp_valid       (resp_valid),
      .resp_data        (resp_data),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .inst_group       (inst_group),
      .inst_group_valid (inst_group_valid),
      .group_pc         (group_pc),
      .out_valid        (out_valid),
      .next_ready       (next_ready)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_stall_cyc   (perf_stall_cyc),
      .perf_fetch_cnt   (perf_fetch_cnt),
      .perf_flush_cnt   (perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endfunction

   // Memory contents: one distinctive line per address.
   function automatic logic [127:0] line_data(input logic [31:0] a);
      if (a == 32'h1c00_0000) return 128'h4444_4444_3333_3333_2222_2222_1111_1111;
      return {a + 32'd12, a + 32'd8, a + 32'd4, a} ^ {4{32'h5a5a_0000}};
   endfunction

   // ---------------------------------------------------------------- memory
   // This process samples accepted requests at the negedge. It answers
   // mem_lat cycles after the accepting edge.
   int unsigned mem_lat = 1;
   initial begin : memory
      logic        acc;
      logic [31:0] acc_addr;
      logic        busy;
      logic [31:0] maddr;
      int unsigned cnt;
      busy = 1'b0; maddr = '0; cnt = 0;
      resp_valid = 1'b0;
      resp_data  = '0;
      forever begin
         @(negedge clk);
         acc      = req_valid && req_ready && !rst;
         acc_addr = req_addr;
         @(posedge clk);
         #1;
         resp_valid = 1'b0;
         if (rst) begin
            busy = 1'b0;
         end else begin
            if (acc) begin
               busy  = 1'b1;
               maddr = acc_addr;
               cnt   = mem_lat - 1;
            end
            if (busy) begin
               if (cnt == 0) begin
                  resp_valid = 1'b1;
                  resp_data  = line_data(maddr);
                  busy       = 1'b0;
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- model
   // The model works at transaction level. It tracks the fetch PC, whether a
   // request is owed a response and whether that response is killed, and a
   // queue of groups waiting to be handed downstream.
   typedef struct {
      logic [127:0] data;
      logic [3:0]   mask;
      logic [31:0]  pc;
   } grp_t;

   grp_t        m_q[$];
   grp_t        g;
   logic [31:0] mpc;
   logic        m_outst, m_killed, m_idle, exp_req, exp_out, hs_out;
   int unsigned m_stall, m_fetch, m_flush;

   initial begin : compare
      mpc = RESET_PC; m_outst = 0; m_killed = 0; m_idle = 1;
      m_stall = 0; m_fetch = 0; m_flush = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mpc = RESET_PC; m_q.delete(); m_outst = 0; m_killed = 0; m_idle = 1;
            m_stall = 0; m_fetch = 0; m_flush = 0;
            chk("rst_req_valid", req_valid, 0);
            chk("rst_out_valid", out_valid, 0);
         end else begin
            exp_out = (m_q.size() != 0);
            exp_req = !m_idle && !m_outst && !exp_out;
            chk("req_valid", req_valid, exp_req);
            chk("req_addr", req_addr, {mpc[31:4], 4'h0});
            chk("out_valid", out_valid, exp_out);
            if (exp_out) begin
               chk("inst_group", inst_group, m_q[0].data);
               chk("inst_group_valid", inst_group_valid, m_q[0].mask);
               chk("group_pc", group_pc, m_q[0].pc);
            end
`ifdef IFU_PERF_CNT_EN
            chk("perf_stall_cyc", perf_stall_cyc, m_stall);
            chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
            chk("perf_flush_cnt", perf_flush_cnt, m_flush);
`endif
            // apply what the coming clock edge does
            m_idle = 0;
            hs_out = exp_out && next_ready;
            if (hs_out) begin
               void'(m_q.pop_front());
               m_fetch++;
            end
            if (exp_out && !next_ready) m_stall++;
            if (resp_valid && m_outst) begin
               if (!m_killed && !redirect_valid) begin
                  g.data = resp_data;
                  g.mask = 4'b1111 << mpc[3:2];
                  g.pc   = mpc;
                  m_q.push_back(g);
                  mpc = {mpc[31:4], 4'h0} + 32'd16;
               end
               m_outst = 0;
            end
            if (exp_req && req_ready) begin
               m_outst  = 1;
               m_killed = 0;
            end
            if (redirect_valid) begin
               m_flush++;
               mpc = redirect_pc;
               if (m_outst) m_killed = 1;
               if (exp_out && !hs_out) void'(m_q.pop_front());
            end
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int unsigned max_cyc);
      int unsigned n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_valid && n < max_cyc);
      chk("wait_req", req_valid, 1);
   endtask

   task automatic wait_out(input int unsigned max_cyc);
      int unsigned n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < max_cyc);
      chk("wait_out", out_valid, 1);
   endtask

   logic [127:0] g0;
   logic [3:0]   m0;
   logic [31:0]  p0;
   logic [31:0]  stall_base;

   initial begin : stimulus
      rst = 1'b1; req_ready = 1'b0; next_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      stall_base = '0;
      repeat (3) tick();
      chk("reset_req_valid", req_valid, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_inst_group", inst_group, 0);
      chk("reset_mask", inst_group_valid, 0);
      chk("reset_group_pc", group_pc, 0);
      chk("reset_req_addr", req_addr, 32'h1c00_0000);

      // first fetch after reset release
      rst = 1'b0; req_ready = 1'b1;
      wait_req(10);
      chk("t1_req_addr", req_addr, 32'h1c00_0000);
      wait_out(10);
      chk("t1_group_pc", group_pc, 32'h1c00_0000);
      chk("t1_mask", inst_group_valid, 4'b1111);
      chk("t1_group", inst_group, 128'h4444_4444_3333_3333_2222_2222_1111_1111);

      // redirect while sitting in the request state
      tick();
      req_ready = 1'b0; next_ready = 1'b1;
      wait_req(10);
      chk("t1_next_req_addr", req_addr, 32'h1c00_0010);
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h1c00_0028;
      tick();
      redirect_valid = 1'b0; req_ready = 1'b1; next_ready = 1'b0;
      wait_out(10);
      chk("t2_group_pc", group_pc, 32'h1c00_0028);
      chk("t2_mask", inst_group_valid, 4'b1100);

      // redirect while waiting; that response arrives later and is dropped
      tick();
      next_ready = 1'b1; mem_lat = 4;
      wait_req(10);
      chk("t2_next_req_addr", req_addr, 32'h1c00_0030);
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'h1c00_0104; next_ready = 1'b0;
      tick();
      redirect_valid = 1'b0; mem_lat = 1;
      wait_req(10);
      chk("t3_req_addr", req_addr, 32'h1c00_0100);
      wait_out(10);
      chk("t3_mask", inst_group_valid, 4'b1110);
      chk("t3_group_pc", group_pc, 32'h1c00_0104);

      // hold the group for five cycles with next_ready low
`ifdef IFU_PERF_CNT_EN
      stall_base = perf_stall_cyc;
`endif
      g0 = inst_group; m0 = inst_group_valid; p0 = group_pc;
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_group", inst_group, g0);
         chk("t4_hold_mask", inst_group_valid, m0);
         chk("t4_hold_pc", group_pc, p0);
         chk("t4_no_req", req_valid, 0);
         if (i < 4) @(negedge clk);
      end
      tick();
      next_ready = 1'b1; req_ready = 1'b0;
      @(negedge clk);
      chk("t4_still_valid", out_valid, 1);
`ifdef IFU_PERF_CNT_EN
      chk("t4_perf_stall", perf_stall_cyc - stall_base, 32'd5);
`endif

      // fetch the top line; the next line address wraps to zero
      tick();
      redirect_valid = 1'b1; redirect_pc = 32'hffff_fff0; mem_lat = 2;
      tick();
      redirect_valid = 1'b0; req_ready = 1'b1;
      wait_out(10);
      chk("t5_group_pc", group_pc, 32'hffff_fff0);
      chk("t5_mask", inst_group_valid, 4'b1111);
      mem_lat = 5;
      wait_req(10);
      chk("t5_wrap_req_addr", req_addr, 32'h0000_0000);

      // reset asserted while waiting for a response
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_req_valid_now", req_valid, 0);
      chk("t6_out_valid_now", out_valid, 0);
      tick();
      tick();
      mem_lat = 1;
      rst = 1'b0;
      wait_req(10);
      chk("t6_req_addr", req_addr, RESET_PC);
      wait_out(10);
      chk("t6_group_pc", group_pc, RESET_PC);

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
